uart_mode_initiator: RTL and testbench

//  Host-side initiator for the UART link's mode-switch protocol. The far-end

---
 rtl/uart_mode_initiator.sv | 134 +++++++++++++
 tb/tb_uart_mode_initiator.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mode_initiator.sv
// uart_mode_initiator: host-side initiator for the UART mode-switch protocol
// Sends FF then {F,mode}, checks both echoes, moves mode_out to the new mode,
// retries a failed attempt up to MAX_RETRY times, then reports err.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/req_mode    mode-switch request, accepted while req_ready (IDLE)
//   tx_data/tx_valid      byte to local TX, transferred when tx_valid && tx_ready
//   tx_ready              local TX can accept a byte / line idle
//   rx_data/rx_valid      one-cycle strobe of a byte from local RX
//   mode_out              current link mode driving local TX/RX
//   done/err              one-cycle pulses: switch succeeded / failed
module uart_mode_initiator #(
    parameter logic [3:0] INIT_MODE      = 4'd1,
    parameter int         TIMEOUT_CYCLES = 200000,
    parameter int         MAX_RETRY      = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    input  logic [3:0] req_mode,
    output logic       req_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [3:0] mode_out,
    output logic       done,
    output logic       err
);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW  = $clog2(MAX_RETRY + 2);
    localparam int GAP = (TIMEOUT_CYCLES / 4 > 0) ? TIMEOUT_CYCLES / 4 : 1;
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] G_LAST = TW'(GAP - 1);
    localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

    // QUIET is the post-failure gap during which RX traffic is ignored
    typedef enum logic [2:0] {IDLE, SEND_FF, WAIT_FF, SEND_M, WAIT_TXD, WAIT_M, QUIET} state_t;

    state_t        state;
    logic [3:0]    new_mode;
    logic [3:0]    old_mode;
    logic [TW-1:0] timer;
    logic [TW-1:0] t_inc;
    logic [RW-1:0] retry;
    logic [7:0]    m_byte;
    logic          timed_out;
    logic          gap_over;

    assign req_ready = state == IDLE;
    assign m_byte    = {4'hF, new_mode};
    assign t_inc     = (timer == T_MAX) ? timer : timer + 1'b1;
    assign timed_out = timer == T_LAST;
    assign gap_over  = timer == G_LAST;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            mode_out <= INIT_MODE;
            new_mode <= INIT_MODE;
            old_mode <= INIT_MODE;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            done     <= 1'b0;
            err      <= 1'b0;
            retry    <= '0;
            timer    <= '0;
        end else begin
            done  <= 1'b0;
            err   <= 1'b0;
            // timer stays cleared outside the states that count
            timer <= '0;
            case (state)
                IDLE: if (req_valid) begin
                    new_mode <= req_mode;
                    old_mode <= mode_out;
                    tx_data  <= 8'hFF;
                    tx_valid <= 1'b1;
                    state    <= SEND_FF;
                end
                SEND_FF: if (tx_ready) begin
                    tx_valid <= 1'b0;
                    state    <= WAIT_FF;
                end
                // a byte arriving on the timeout cycle is judged, not discarded
                WAIT_FF: if (rx_valid && rx_data == 8'hFF) begin
                    tx_data  <= m_byte;
                    tx_valid <= 1'b1;
                    state    <= SEND_M;
                end else if (rx_valid || timed_out) begin
                    mode_out <= old_mode;
                    state    <= QUIET;
                end else begin
                    timer <= t_inc;
                end
                SEND_M: if (tx_ready) begin
                    tx_valid <= 1'b0;
                    state    <= WAIT_TXD;
                end
                // switch locally only once our byte has left the line, since the
                // responder echoes in the new mode
                WAIT_TXD: if (tx_ready) begin
                    mode_out <= new_mode;
                    state    <= WAIT_M;
                end
                WAIT_M: if (rx_valid && rx_data == m_byte) begin
                    done  <= 1'b1;
                    retry <= '0;
                    state <= IDLE;
                end else if (rx_valid || timed_out) begin
                    mode_out <= old_mode;
                    state    <= QUIET;
                end else begin
                    timer <= t_inc;
                end
                QUIET: if (!gap_over) begin
                    timer <= t_inc;
                end else if (retry < R_MAX) begin
                    retry    <= retry + 1'b1;
                    tx_data  <= 8'hFF;
                    tx_valid <= 1'b1;
                    state    <= SEND_FF;
                end else begin
                    err   <= 1'b1;
                    retry <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mode_initiator.sv
// tb_uart_mode_initiator: directed bench with a local TX and echoing responder model
module tb_uart_mode_initiator;
    localparam int TO = 1000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [3:0] req_mode = 4'd0;
    logic       req_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [3:0] mode_out;
    logic       done;
    logic       err;

    uart_mode_initiator #(.INIT_MODE(4'd1), .TIMEOUT_CYCLES(TO), .MAX_RETRY(2)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_mode(req_mode),
        .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .mode_out(mode_out), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int tx_busy = 0;
    int echo_cnt = 0;
    int echo_dly = 100;
    logic [7:0] echo_byte = 8'h00;
    logic bad_ff = 1'b0;
    logic drop_m = 1'b0;
    logic hold_low = 1'b0;
    logic [7:0] tx_log [64];
    int acc_cyc [64];
    int nlog = 0;
    int n_done = 0, n_err = 0, n_both = 0, n_wide = 0, n_acc = 0;
    int n_mchg = 0, mchg_cyc = 0, prev_mchg = 0;
    logic [3:0] prev_mode = 4'd1;
    logic prev_pulse = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // one clock: local TX (busy 20 cycles per byte), responder echo, event capture
    task automatic tick();
        logic acc;
        logic racc;
        logic [7:0] b;
        acc  = tx_valid && tx_ready;
        racc = req_valid && req_ready;
        b    = tx_data;
        @(posedge clk);
        #1;
        cyc++;
        if (racc) n_acc++;
        if (tx_busy > 0) tx_busy--;
        rx_valid = 1'b0;
        if (echo_cnt > 0) begin
            echo_cnt--;
            if (echo_cnt == 0) begin
                rx_valid = 1'b1;
                rx_data  = echo_byte;
            end
        end
        if (acc) begin
            if (nlog < 64) begin
                tx_log[nlog]  = b;
                acc_cyc[nlog] = cyc;
                nlog++;
            end
            tx_busy = 20;
            if (!(drop_m && b != 8'hFF)) begin
                echo_cnt  = echo_dly;
                echo_byte = (bad_ff && b == 8'hFF) ? 8'hFE : b;
            end
        end
        tx_ready = (tx_busy == 0) && !hold_low;
        if (done) n_done++;
        if (err) n_err++;
        if (done && err) n_both++;
        if ((done || err) && prev_pulse) n_wide++;
        prev_pulse = done || err;
        if (mode_out != prev_mode) begin
            n_mchg++;
            prev_mchg = mchg_cyc;
            mchg_cyc  = cyc;
        end
        prev_mode = mode_out;
    endtask

    task automatic start(input logic [3:0] m);
        req_mode  = m;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_end(input int limit, input string tag);
        int n0;
        int k;
        n0 = n_done + n_err;
        k  = 0;
        while (n_done + n_err == n0 && k < limit) begin
            tick();
            k++;
        end
        check({tag, "_finished"}, 32'(k < limit), 32'd1);
    endtask

    initial begin
        int l0, d0, e0, c0, a0, nr, k, bad, tbad;
        tick();
        tick();
        check("rst_mode", 32'(mode_out), 32'd1);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_pulses", 32'({done, err}), 32'd0);
        reset_n = 1'b1;
        tick();

        // normal switch 1 -> 3
        l0 = nlog; d0 = n_done; e0 = n_err; c0 = n_mchg;
        start(4'd3);
        wait_end(5000, "t1");
        check("t1_nbytes", 32'(nlog - l0), 32'd2);
        check("t1_byte0", 32'(tx_log[l0]), 32'hFF);
        check("t1_byte1", 32'(tx_log[l0+1]), 32'hF3);
        check("t1_done", 32'(n_done - d0), 32'd1);
        check("t1_err", 32'(n_err - e0), 32'd0);
        check("t1_mode", 32'(mode_out), 32'd3);
        check("t1_mode_chg_lat", 32'(mchg_cyc - acc_cyc[l0+1]), 32'd21);
        check("t1_mode_chg_n", 32'(n_mchg - c0), 32'd1);

        // back to mode 1 so later expectations start from INIT_MODE
        start(4'd1);
        wait_end(5000, "t1b");
        check("t1b_mode", 32'(mode_out), 32'd1);

        // FF echoed as FE: three FF attempts, then err
        bad_ff = 1'b1;
        l0 = nlog; d0 = n_done; e0 = n_err; c0 = n_mchg;
        start(4'd4);
        wait_end(10000, "t2");
        bad_ff = 1'b0;
        check("t2_nbytes", 32'(nlog - l0), 32'd3);
        check("t2_b0", 32'(tx_log[l0]), 32'hFF);
        check("t2_b2", 32'(tx_log[l0+2]), 32'hFF);
        check("t2_retry_gap", 32'(acc_cyc[l0+1] - acc_cyc[l0]), 32'd352);
        check("t2_err", 32'(n_err - e0), 32'd1);
        check("t2_done", 32'(n_done - d0), 32'd0);
        check("t2_mode", 32'(mode_out), 32'd1);
        check("t2_mode_chg_n", 32'(n_mchg - c0), 32'd0);

        // mode byte never echoed: mode goes to 5 and back after TO cycles
        drop_m = 1'b1;
        l0 = nlog; d0 = n_done; e0 = n_err; c0 = n_mchg;
        start(4'd5);
        wait_end(20000, "t3");
        drop_m = 1'b0;
        check("t3_nbytes", 32'(nlog - l0), 32'd6);
        check("t3_b5", 32'(tx_log[l0+5]), 32'hF5);
        check("t3_revert_lat", 32'(mchg_cyc - prev_mchg), 32'd1000);
        check("t3_mode_chg_n", 32'(n_mchg - c0), 32'd6);
        check("t3_err", 32'(n_err - e0), 32'd1);
        check("t3_done", 32'(n_done - d0), 32'd0);
        check("t3_mode", 32'(mode_out), 32'd1);

        // req_valid held high; second request only taken once back in IDLE
        l0 = nlog; d0 = n_done; a0 = n_acc; nr = 0; k = 0;
        req_mode = 4'd4;
        req_valid = 1'b1;
        tick();
        req_mode = 4'd7;
        while (n_done == d0 && k < 5000) begin
            if (req_ready) nr++;
            tick();
            k++;
        end
        check("t4_finished", 32'(k < 5000), 32'd1);
        check("t4_ready_busy", 32'(nr), 32'd0);
        check("t4_accepts_first", 32'(n_acc - a0), 32'd1);
        check("t4_mode_first", 32'(mode_out), 32'd4);
        check("t4_ready_idle", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check("t4_accepts_second", 32'(n_acc - a0), 32'd2);
        wait_end(5000, "t4b");
        check("t4_b1", 32'(tx_log[l0+1]), 32'hF4);
        check("t4_b3", 32'(tx_log[l0+3]), 32'hF7);
        check("t4_mode_second", 32'(mode_out), 32'd7);

        // asynchronous reset while in WAIT_M
        d0 = n_done; e0 = n_err; k = 0;
        start(4'd9);
        while (mode_out != 4'd9 && k < 2000) begin
            tick();
            k++;
        end
        check("t5_reached_wait_m", 32'(mode_out), 32'd9);
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_rst_mode", 32'(mode_out), 32'd1);
        check("t5_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("t5_rst_ready", 32'(req_ready), 32'd1);
        echo_cnt = 0;
        tx_busy = 0;
        rx_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("t5_no_done", 32'(n_done - d0), 32'd0);
        check("t5_no_err", 32'(n_err - e0), 32'd0);
        check("t5_mode_after", 32'(mode_out), 32'd1);

        // tx_ready held low for 50 cycles while F2 is offered
        l0 = nlog; d0 = n_done; k = 0;
        start(4'd2);
        while (nlog == l0 && k < 2000) begin
            tick();
            k++;
        end
        hold_low = 1'b1;
        k = 0;
        while (!(tx_valid && tx_data == 8'hF2) && k < 2000) begin
            tick();
            k++;
        end
        check("t6_offer_f2", 32'(tx_data), 32'hF2);
        bad = 0; tbad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!(tx_valid && tx_data == 8'hF2)) bad++;
            if (dut.timer != 0) tbad++;
        end
        check("t6_held_stable", 32'(bad), 32'd0);
        check("t6_timer_idle", 32'(tbad), 32'd0);
        check("t6_no_accept", 32'(nlog - l0), 32'd1);
        hold_low = 1'b0;
        wait_end(5000, "t6");
        check("t6_done", 32'(n_done - d0), 32'd1);
        check("t6_mode", 32'(mode_out), 32'd2);

        // echo landing on the last timeout cycle is accepted
        echo_dly = 999;
        d0 = n_done; e0 = n_err;
        start(4'd6);
        wait_end(10000, "t7");
        echo_dly = 100;
        check("t7_done", 32'(n_done - d0), 32'd1);
        check("t7_err", 32'(n_err - e0), 32'd0);
        check("t7_mode", 32'(mode_out), 32'd6);

        // same mode still runs the whole sequence; extreme mode values
        l0 = nlog; d0 = n_done;
        start(4'd6);
        wait_end(5000, "t8");
        check("t8_nbytes", 32'(nlog - l0), 32'd2);
        check("t8_byte1", 32'(tx_log[l0+1]), 32'hF6);
        check("t8_done", 32'(n_done - d0), 32'd1);
        start(4'd15);
        wait_end(5000, "t8f");
        check("t8_mode15", 32'(mode_out), 32'd15);
        start(4'd0);
        wait_end(5000, "t8z");
        check("t8_mode0", 32'(mode_out), 32'd0);

        check("never_both", 32'(n_both), 32'd0);
        check("single_cycle_pulses", 32'(n_wide), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
